mem_arbiter: RTL and testbench

Two-port round-robin arbiter in front of the single-port 256-byte data memory `Mem`. It lets two requesters share the one memory port, for example the instruction-fetch stage (m0) and the load/store stage (m1). Each requester gets a request/grant handshake, a registered one-cycle read/ack response, and misalignment detection. The block drives `Mem`'s `w_en`/`addr`/`data_in` and samples its `data_out`.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/mem_arbiter.sv | 83 ++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared widths, requester index and response record for mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_idx_e;

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way round-robin grant with a one-bit priority pointer.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_e r_prio;

    // Grants are suppressed while reset is asserted so no access can start.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b11) begin
                gnt = (r_prio == REQ_M0) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= REQ_M0;
        end else if (gnt[0]) begin
            r_prio <= REQ_M1;
        end else if (gnt[1]) begin
            r_prio <= REQ_M0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Round-robin sharing of one memory port between two requesters,
//           with alignment checking and registered one-cycle responses.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_misal;
    rsp_t [1:0]        r_rsp;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .gnt   (w_gnt)
    );

    assign w_any   = |w_gnt;
    assign w_we    = w_gnt[REQ_M1] ? m1_we    : m0_we;
    assign w_addr  = w_gnt[REQ_M1] ? m1_addr  : m0_addr;
    assign w_wdata = w_gnt[REQ_M1] ? m1_wdata : m0_wdata;
    assign w_misal = (w_addr[1:0] != 2'b00);

    // Idle cycles present an all-zero bus; misaligned writes never reach memory.
    assign mem_w_en    = w_any & w_we & ~w_misal;
    assign mem_addr    = w_any ? w_addr  : '0;
    assign mem_data_in = w_any ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_rsp[i].rvalid <= w_gnt[i];
                r_rsp[i].err    <= w_gnt[i] & w_misal;
                r_rsp[i].rdata  <= (w_gnt[i] && !w_we && !w_misal) ? mem_data_out : '0;
            end
        end
    end

    assign m0_gnt    = w_gnt[REQ_M0];
    assign m1_gnt    = w_gnt[REQ_M1];
    assign m0_rvalid = r_rsp[REQ_M0].rvalid;
    assign m0_err    = r_rsp[REQ_M0].err;
    assign m0_rdata  = r_rsp[REQ_M0].rdata;
    assign m1_rvalid = r_rsp[REQ_M1].rvalid;
    assign m1_err    = r_rsp[REQ_M1].err;
    assign m1_rdata  = r_rsp[REQ_M1].rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed vector table, corner sequences and randomized traffic
//           against a behavioural memory/arbitration model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [7:0]  m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_w_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data_in, mem_data_out;

    logic [31:0] mem [64];
    logic        wr_pend = 1'b0;
    logic [7:0]  wr_a;
    logic [31:0] wr_d;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_addr[7:2]];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    typedef struct {
        logic        rst_n;
        logic        r0, w0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [1:0]  gnt;
        logic        wen;
        logic [1:0]  rv;
        logic [1:0]  err;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic r0, logic w0, logic [7:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [7:0] a1, logic [31:0] d1,
                                logic [1:0] g, logic wen, logic [1:0] rv, logic [1:0] er,
                                logic [31:0] rd0, logic [31:0] rd1);
        vec_t v;
        v.rst_n = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.gnt = g; v.wen = wen; v.rv = rv; v.err = er; v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory model: a write seen during a cycle commits at that cycle's closing edge.
    task automatic step();
        @(posedge clk);
        if (wr_pend) mem[wr_a[7:2]] = wr_d;
        wr_pend = 1'b0;
        #1;
    endtask

    task automatic settle();
        #3;
        wr_pend = mem_w_en;
        wr_a    = mem_addr;
        wr_d    = mem_data_in;
    endtask

    task automatic drive(logic rs, logic r0, logic w0, logic [7:0] a0, logic [31:0] d0,
                         logic r1, logic w1, logic [7:0] a1, logic [31:0] d1);
        rst_n = rs;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    // Behavioural reference state for the random phase.
    logic [31:0] ref_mem [64];
    int          mprio;
    logic [1:0]  exp_rv, exp_er, last_g;
    logic [31:0] exp_rd [2];
    logic        q_req [2], q_we [2];
    logic [7:0]  q_addr [2];
    logic [31:0] q_wd [2];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;

        tbl.push_back(mk(0, 1,0,8'h00,0, 1,0,8'h10,0, 2'b00,0,2'b00,2'b00,0,0));
        tbl.push_back(mk(0, 1,0,8'h00,0, 1,0,8'h10,0, 2'b00,0,2'b00,2'b00,0,0));
        tbl.push_back(mk(0, 1,0,8'h00,0, 1,0,8'h10,0, 2'b00,0,2'b00,2'b00,0,0));
        tbl.push_back(mk(1, 1,0,8'h00,0, 1,0,8'h10,0, 2'b01,0,2'b00,2'b00,0,0));
        tbl.push_back(mk(1, 1,0,8'h00,0, 1,0,8'h10,0, 2'b10,0,2'b01,2'b00,32'hA000_0000,0));
        tbl.push_back(mk(1, 1,0,8'h00,0, 1,0,8'h10,0, 2'b01,0,2'b10,2'b00,0,32'hA000_0004));
        tbl.push_back(mk(1, 1,0,8'h00,0, 1,0,8'h10,0, 2'b10,0,2'b01,2'b00,32'hA000_0000,0));
        tbl.push_back(mk(1, 1,1,8'h04,32'hDEADBEEF, 0,0,8'h00,0, 2'b01,1,2'b10,2'b00,0,32'hA000_0004));
        tbl.push_back(mk(1, 1,0,8'h04,0, 0,0,8'h00,0, 2'b01,0,2'b01,2'b00,0,0));
        tbl.push_back(mk(1, 0,0,8'h00,0, 1,0,8'h10,0, 2'b10,0,2'b01,2'b00,32'hDEADBEEF,0));
        tbl.push_back(mk(1, 1,1,8'h08,32'h11111111, 1,0,8'h08,0, 2'b01,1,2'b10,2'b00,0,32'hA000_0004));
        tbl.push_back(mk(1, 0,0,8'h00,0, 1,0,8'h08,0, 2'b10,0,2'b01,2'b00,0,0));
        tbl.push_back(mk(1, 0,0,8'h00,0, 0,0,8'h00,0, 2'b00,0,2'b10,2'b00,0,32'h11111111));
        tbl.push_back(mk(1, 0,0,8'h00,0, 1,1,8'h06,32'hFFFFFFFF, 2'b10,0,2'b00,2'b00,0,0));
        tbl.push_back(mk(1, 0,0,8'h00,0, 1,0,8'h04,0, 2'b10,0,2'b10,2'b10,0,0));
        tbl.push_back(mk(1, 0,0,8'h00,0, 0,0,8'h00,0, 2'b00,0,2'b10,2'b00,0,32'hDEADBEEF));

        foreach (tbl[k]) begin
            step();
            drive(tbl[k].rst_n, tbl[k].r0, tbl[k].w0, tbl[k].a0, tbl[k].d0,
                  tbl[k].r1, tbl[k].w1, tbl[k].a1, tbl[k].d1);
            settle();
            chk($sformatf("vec%0d gnt", k), {30'd0, m1_gnt, m0_gnt}, {30'd0, tbl[k].gnt});
            chk($sformatf("vec%0d mem_w_en", k), {31'd0, mem_w_en}, {31'd0, tbl[k].wen});
            chk($sformatf("vec%0d rvalid", k), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, tbl[k].rv});
            if (tbl[k].gnt == 2'b00) begin
                chk($sformatf("vec%0d idle mem_addr", k), {24'd0, mem_addr}, 32'd0);
                chk($sformatf("vec%0d idle mem_data_in", k), mem_data_in, 32'd0);
            end
            if (tbl[k].rv[0]) begin
                chk($sformatf("vec%0d m0_err", k), {31'd0, m0_err}, {31'd0, tbl[k].err[0]});
                chk($sformatf("vec%0d m0_rdata", k), m0_rdata, tbl[k].rd0);
            end
            if (tbl[k].rv[1]) begin
                chk($sformatf("vec%0d m1_err", k), {31'd0, m1_err}, {31'd0, tbl[k].err[1]});
                chk($sformatf("vec%0d m1_rdata", k), m1_rdata, tbl[k].rd1);
            end
        end

        // Reset asserted just before the edge that closes a grant cycle.
        step();
        drive(1, 1,0,8'h00,0, 0,0,8'h00,0);
        settle();
        chk("midrst gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        #3 rst_n = 1'b0;
        step();
        drive(0, 0,0,8'h00,0, 1,0,8'h10,0);
        settle();
        chk("midrst rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        chk("midrst gnt held", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        step();
        drive(1, 1,0,8'h00,0, 1,0,8'h10,0);
        settle();
        chk("midrst prio back to m0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
        step();
        drive(1, 0,0,8'h00,0, 0,0,8'h00,0);
        settle();
        chk("midrst followup rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
        chk("midrst followup rdata", m0_rdata, 32'hA000_0000);

        // Randomized traffic: m0 was granted last, so m1 holds priority.
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        mprio  = 1;
        exp_rv = 2'b00;
        exp_er = 2'b00;
        last_g = 2'b00;
        for (int p = 0; p < 2; p++) begin
            q_req[p] = 0; q_we[p] = 0; q_addr[p] = 0; q_wd[p] = 0; exp_rd[p] = 0;
        end

        for (int cyc = 0; cyc < 500; cyc++) begin
            logic       rs;
            logic [1:0] g;
            int         win;
            logic [7:0] a;
            logic [1:0] n_rv, n_er;
            logic [31:0] n_rd [2];

            rs = ($urandom_range(0, 39) != 0);
            for (int p = 0; p < 2; p++) begin
                if (!(q_req[p] && !last_g[p])) begin
                    q_req[p] = ($urandom_range(0, 2) != 0);
                    q_we[p]  = $urandom_range(0, 1) == 1;
                    a        = 8'($urandom_range(0, 7) << 2);
                    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    q_addr[p] = a;
                    q_wd[p]   = $urandom;
                end
            end

            step();
            drive(rs, q_req[0], q_we[0], q_addr[0], q_wd[0], q_req[1], q_we[1], q_addr[1], q_wd[1]);
            settle();

            g   = 2'b00;
            win = -1;
            if (rs) begin
                if (q_req[0] && q_req[1]) win = mprio;
                else if (q_req[0])        win = 0;
                else if (q_req[1])        win = 1;
            end
            if (win >= 0) g[win] = 1'b1;

            chk($sformatf("rnd%0d gnt", cyc), {30'd0, m1_gnt, m0_gnt}, {30'd0, g});
            chk($sformatf("rnd%0d mem_w_en", cyc), {31'd0, mem_w_en},
                {31'd0, (win >= 0) && q_we[win] && (q_addr[win][1:0] == 2'b00)});
            chk($sformatf("rnd%0d rvalid", cyc), {30'd0, m1_rvalid, m0_rvalid}, {30'd0, exp_rv});
            if (exp_rv[0]) begin
                chk($sformatf("rnd%0d m0_err", cyc), {31'd0, m0_err}, {31'd0, exp_er[0]});
                chk($sformatf("rnd%0d m0_rdata", cyc), m0_rdata, exp_rd[0]);
            end
            if (exp_rv[1]) begin
                chk($sformatf("rnd%0d m1_err", cyc), {31'd0, m1_err}, {31'd0, exp_er[1]});
                chk($sformatf("rnd%0d m1_rdata", cyc), m1_rdata, exp_rd[1]);
            end

            n_rv = 2'b00; n_er = 2'b00; n_rd[0] = 0; n_rd[1] = 0;
            if (win >= 0) begin
                n_rv[win] = 1'b1;
                if (q_addr[win][1:0] != 2'b00) begin
                    n_er[win] = 1'b1;
                end else if (q_we[win]) begin
                    ref_mem[q_addr[win][7:2]] = q_wd[win];
                end else begin
                    n_rd[win] = ref_mem[q_addr[win][7:2]];
                end
                mprio = 1 - win;
            end
            if (!rs) mprio = 0;
            exp_rv = n_rv; exp_er = n_er; exp_rd[0] = n_rd[0]; exp_rd[1] = n_rd[1];
            last_g = g;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
